// File: rtl/data_memory_unit_if.sv
// MEM-stage data memory bus: request side driven by the pipeline,
// response side driven by data_memory_unit.
interface data_memory_unit_if;
    logic [1:0]  MemRead;
    logic [1:0]  MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        access_error;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, rvalid, stall, access_error
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, rvalid, stall, access_error
    );
endinterface

// File: rtl/data_memory_unit.sv
// Multi-cycle little-endian data memory with byte/halfword/word access,
// sign-extending loads, alignment checking and a pipeline stall output.
//
// state | meaning
// IDLE  | waiting for a request; errors are flagged combinationally here
// BUSY  | access in flight, counter runs down to the commit edge
// DONE  | result cycle; rvalid pulses for loads, stall released
module data_memory_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   counter;
    logic            load_q;
    logic [1:0]      size_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            req, err, accept, commit, stall, access_error;
    logic [1:0]      size_in;
    logic [31:0]     word, load_val;
    logic [3:0]      be;
    logic            unused_addr;

    assign unused_addr = ^bus.addr[31:AW+2];

    assign req     = (bus.MemRead != 2'b00) || (bus.MemWrite != 2'b00);
    assign size_in = (bus.MemRead != 2'b00) ? bus.MemRead : bus.MemWrite;
    assign err     = ((bus.MemRead != 2'b00) && (bus.MemWrite != 2'b00))
                   || ((size_in == 2'b01) && (bus.addr[1:0] != 2'b00))
                   || ((size_in == 2'b11) && bus.addr[0]);

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        access_error = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (req && err) begin
                    access_error = 1'b1;
                end else if (req) begin
                    stall     = 1'b1;
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (counter == CW'(1)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign commit = (state == BUSY) && (counter == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            rdata_q <= '0;
            load_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                counter <= CW'(LATENCY);
                load_q  <= (bus.MemRead != 2'b00);
                size_q  <= size_in;
                addr_q  <= bus.addr[AW+1:0];
                // Replicate narrow store data onto every lane so the
                // byte enables alone pick what lands in the array.
                case (size_in)
                    2'b10:   wdata_q <= {4{bus.wdata[7:0]}};
                    2'b11:   wdata_q <= {2{bus.wdata[15:0]}};
                    default: wdata_q <= bus.wdata;
                endcase
            end else if (state == BUSY) begin
                counter <= counter - CW'(1);
            end
            if (commit && load_q) rdata_q <= load_val;
        end
    end

    always_comb begin
        case (size_q)
            2'b10:   be = 4'b0001 << addr_q[1:0];
            2'b11:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && !load_q && !reset) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[addr_q[AW+1:2]][8*k +: 8] <= wdata_q[8*k +: 8];
        end
    end

    assign word = mem[addr_q[AW+1:2]];

    always_comb begin
        load_val = word;
        case (size_q)
            2'b10: begin
                case (addr_q[1:0])
                    2'd0:    load_val = {{24{word[7]}},  word[7:0]};
                    2'd1:    load_val = {{24{word[15]}}, word[15:8]};
                    2'd2:    load_val = {{24{word[23]}}, word[23:16]};
                    default: load_val = {{24{word[31]}}, word[31:24]};
                endcase
            end
            2'b11: load_val = addr_q[1] ? {{16{word[31]}}, word[31:16]}
                                        : {{16{word[15]}}, word[15:0]};
            default: load_val = word;
        endcase
    end

    assign bus.rdata        = rdata_q;
    assign bus.rvalid       = (state == DONE) && load_q;
    assign bus.stall        = stall;
    assign bus.access_error = access_error;
endmodule

// File: tb/tb_data_memory_unit.sv
// Scoreboard bench: two instances (LATENCY 1 and 3) against a byte-array model.
module tb_data_memory_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic [1:0]  mr  [2];
    logic [1:0]  mw  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic [31:0] rd  [2];
    logic        rv  [2];
    logic        st  [2];
    logic        ae  [2];

    data_memory_unit_if bus0 ();
    data_memory_unit_if bus1 ();

    assign bus0.MemRead = mr[0]; assign bus0.MemWrite = mw[0];
    assign bus0.addr    = ad[0]; assign bus0.wdata    = wd[0];
    assign bus1.MemRead = mr[1]; assign bus1.MemWrite = mw[1];
    assign bus1.addr    = ad[1]; assign bus1.wdata    = wd[1];
    assign rd[0] = bus0.rdata; assign rv[0] = bus0.rvalid;
    assign st[0] = bus0.stall; assign ae[0] = bus0.access_error;
    assign rd[1] = bus1.rdata; assign rv[1] = bus1.rvalid;
    assign st[1] = bus1.stall; assign ae[1] = bus1.access_error;

    data_memory_unit #(.DEPTH_WORDS(256), .LATENCY(1)) dut0 (
        .clk(clk), .reset(rst[0]), .bus(bus0));
    data_memory_unit #(.DEPTH_WORDS(256), .LATENCY(3)) dut1 (
        .clk(clk), .reset(rst[1]), .bus(bus1));

    int checks = 0;
    int errors = 0;
    logic [31:0] expq [2][$];
    logic [7:0]  refm [2][1024];

    function automatic int lat(int s);
        return (s == 0) ? 1 : 3;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'b01) ? 4 : (sz == 2'b10) ? 1 : 2;
    endfunction

    function automatic logic [31:0] ref_load(int s, logic [1:0] sz, logic [31:0] a);
        logic [31:0] v = '0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = refm[s][(int'(a[9:0]) + i) % 1024];
        if (n == 1) v = {{24{v[7]}}, v[7:0]};
        if (n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(int s, logic [1:0] sz, logic [31:0] a, logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) refm[s][(int'(a[9:0]) + i) % 1024] = d[8*i +: 8];
    endtask

    // Issue one MEM-stage instruction and hold it until the unit releases stall.
    task automatic op(int s, logic [1:0] r, logic [1:0] w, logic [31:0] a, logic [31:0] d);
        logic [1:0] sz;
        logic       err;
        int         cnt;
        sz  = (r != 2'b00) ? r : w;
        err = (r != 2'b00 && w != 2'b00) || (sz == 2'b01 && a[1:0] != 2'b00)
              || (sz == 2'b11 && a[0]);
        @(negedge clk);
        mr[s] = r; mw[s] = w; ad[s] = a; wd[s] = d;
        #1;
        if (r == 2'b00 && w == 2'b00) begin
            check("idle_stall", 32'(st[s]), 0);
        end else if (err) begin
            check("err_flag", 32'(ae[s]), 1);
            check("err_stall", 32'(st[s]), 0);
            @(posedge clk); #1;
            check("err_stays_idle", 32'(st[s]), 0);
        end else begin
            check("req_no_err", 32'(ae[s]), 0);
            if (r != 2'b00) expq[s].push_back(ref_load(s, r, a));
            else            ref_store(s, w, a, d);
            cnt = 0;
            while (st[s] === 1'b1 && cnt < 20) begin
                cnt++;
                @(negedge clk); #1;
            end
            check($sformatf("stall_len_s%0d", s), cnt, lat(s) + 1);
        end
        mr[s] = 2'b00; mw[s] = 2'b00; ad[s] = '0; wd[s] = '0;
    endtask

    task automatic reset_mid_busy(int s);
        op(s, 2'b00, 2'b01, 32'h40, 32'h1111_1111);
        @(negedge clk);
        mr[s] = 2'b00; mw[s] = 2'b01; ad[s] = 32'h40; wd[s] = 32'hAAAA_5555;
        @(negedge clk);
        rst[s] = 1'b1;
        @(negedge clk);
        rst[s] = 1'b0;
        mw[s] = 2'b00; ad[s] = '0; wd[s] = '0;
        #1;
        check("rst_mid_stall", 32'(st[s]), 0);
        check("rst_mid_rvalid", 32'(rv[s]), 0);
        check("rst_mid_rdata", rd[s], 0);
        op(s, 2'b01, 2'b00, 32'h40, 32'h0);
    endtask

    always @(negedge clk) begin
        #1;
        for (int s = 0; s < 2; s++) begin
            if (rv[s] === 1'b1) begin
                if (expq[s].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid s%0d actual=1 required=0", s);
                end else begin
                    check($sformatf("rdata_s%0d", s), rd[s], expq[s].pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; mr[s] = 2'b00; mw[s] = 2'b00; ad[s] = '0; wd[s] = '0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) rst[s] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_rdata", rd[s], 0);
            check("reset_rvalid", 32'(rv[s]), 0);
            check("reset_stall", 32'(st[s]), 0);
            check("reset_err", 32'(ae[s]), 0);
        end

        // Word round trip
        op(0, 2'b00, 2'b01, 32'h10, 32'hDEAD_BEEF);
        op(0, 2'b01, 2'b00, 32'h10, 32'h0);
        // Byte lanes
        op(0, 2'b00, 2'b01, 32'h20, 32'h0);
        op(0, 2'b00, 2'b10, 32'h21, 32'h0000_0081);
        op(0, 2'b10, 2'b00, 32'h21, 32'h0);
        op(0, 2'b01, 2'b00, 32'h20, 32'h0);
        // Halfwords
        op(0, 2'b00, 2'b11, 32'h32, 32'h0000_7FFF);
        op(0, 2'b11, 2'b00, 32'h32, 32'h0);
        op(0, 2'b00, 2'b11, 32'h30, 32'h0000_8001);
        op(0, 2'b01, 2'b00, 32'h30, 32'h0);
        // Errors leave memory untouched
        op(0, 2'b00, 2'b01, 32'h04, 32'h0BAD_F00D);
        op(0, 2'b01, 2'b00, 32'h13, 32'h0);
        op(0, 2'b00, 2'b11, 32'h05, 32'h0000_FFFF);
        op(0, 2'b01, 2'b01, 32'h04, 32'h1234_5678);
        op(0, 2'b01, 2'b00, 32'h04, 32'h0);
        op(0, 2'b01, 2'b00, 32'h10, 32'h0);
        // Latency 3 and address wrap
        op(1, 2'b00, 2'b01, 32'h400, 32'h1234_5678);
        op(1, 2'b01, 2'b00, 32'h0, 32'h0);
        // Reset while a store is in flight
        reset_mid_busy(0);
        reset_mid_busy(1);

        // Random traffic over a pre-written window, high address bits random
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) op(s, 2'b00, 2'b01, 32'(i * 4), $urandom);
            for (int i = 0; i < 80; i++) begin
                logic [1:0]  r, w;
                logic [31:0] a;
                r = 2'($urandom_range(0, 3));
                w = ($urandom_range(0, 5) == 0 || r == 2'b00) ? 2'($urandom_range(0, 3)) : 2'b00;
                a = $urandom & 32'hFFFF_FC3F;
                op(s, r, w, a, $urandom);
            end
        end

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) check($sformatf("queue_drained_s%0d", s), expq[s].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
